// File: rtl/ota_reboot_sequencer_if.sv
// Request/grant, RP2040 handshake and reboot-trigger signals of ota_reboot_sequencer.
// Optional i_abort member exists only when OTA_REBOOT_ABORT_EN is defined.
interface ota_reboot_sequencer_if #(
   parameter int unsigned N_REQ = 3
) ();
   logic             i_arm;
   logic [N_REQ-1:0] i_req;
   logic [N_REQ-1:0] i_req_slot;
   logic             i_host_ack;
   logic             i_err_clr;
`ifdef OTA_REBOOT_ABORT_EN
   logic             i_abort;
`endif
   logic [N_REQ-1:0] o_grant;
   logic             o_busy;
   logic             o_host_req;
   logic             o_host_slot;
   logic             o_reboot_trigger;
   logic [31:0]      o_reboot_addr;
   logic             o_timeout_err;

`ifdef OTA_REBOOT_ABORT_EN
   modport slave (
      input  i_arm, i_req, i_req_slot, i_host_ack, i_err_clr, i_abort,
      output o_grant, o_busy, o_host_req, o_host_slot, o_reboot_trigger, o_reboot_addr,
             o_timeout_err
   );
   modport master (
      output i_arm, i_req, i_req_slot, i_host_ack, i_err_clr, i_abort,
      input  o_grant, o_busy, o_host_req, o_host_slot, o_reboot_trigger, o_reboot_addr,
             o_timeout_err
   );
`else
   modport slave (
      input  i_arm, i_req, i_req_slot, i_host_ack, i_err_clr,
      output o_grant, o_busy, o_host_req, o_host_slot, o_reboot_trigger, o_reboot_addr,
             o_timeout_err
   );
   modport master (
      output i_arm, i_req, i_req_slot, i_host_ack, i_err_clr,
      input  o_grant, o_busy, o_host_req, o_host_slot, o_reboot_trigger, o_reboot_addr,
             o_timeout_err
   );
`endif
endinterface

// File: rtl/ota_reboot_sequencer.sv
// Round-robin owner of the ECP5 reboot path: RP2040 handshake first, internal refresh on timeout.
// Optional abort input enabled by defining OTA_REBOOT_ABORT_EN.
module ota_reboot_sequencer #(
   parameter int unsigned N_REQ              = 3,
   parameter int unsigned HOLDOFF_CYCLES     = 1024,
   parameter int unsigned ACK_TIMEOUT_CYCLES = 65536,
   parameter logic [31:0] GOLDEN_ADDR        = 32'h0000_0000,
   parameter logic [31:0] USER_ADDR          = 32'h0010_0000
) (
   input logic                  clk,
   input logic                  rst,
   ota_reboot_sequencer_if.slave bus
);
   localparam int unsigned PtrW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CntMax = (HOLDOFF_CYCLES > ACK_TIMEOUT_CYCLES) ?
                                    HOLDOFF_CYCLES : ACK_TIMEOUT_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   typedef enum logic [2:0] {StIdle, StHoldoff, StHostReq, StWaitRel, StFallback} state_e;

   state_e           r_state;
   logic [CntW-1:0]  r_cnt;
   logic [PtrW-1:0]  r_ptr;
   logic [1:0]       r_ack_sync;
   logic [N_REQ-1:0] r_grant;
   logic             r_busy;
   logic             r_host_req;
   logic             r_host_slot;
   logic             r_trigger;
   logic [31:0]      r_addr;
   logic             r_timeout_err;

   logic             w_sel_valid;
   logic [PtrW-1:0]  w_sel_idx;
   logic [PtrW-1:0]  w_ptr_next;
   logic [N_REQ-1:0] w_sel_onehot;
   logic             w_sel_slot;
   logic             w_abort;

`ifdef OTA_REBOOT_ABORT_EN
   assign w_abort = bus.i_abort;
`else
   assign w_abort = 1'b0;
`endif

   // First requester at or after the pointer, wrapping around.
   always_comb begin
      int unsigned idx;
      idx          = 0;
      w_sel_valid  = 1'b0;
      w_sel_idx    = '0;
      w_sel_onehot = '0;
      w_sel_slot   = 1'b0;
      w_ptr_next   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (int'(r_ptr) + k) % N_REQ;
         if (!w_sel_valid && bus.i_req[idx]) begin
            w_sel_valid       = 1'b1;
            w_sel_idx         = PtrW'(idx);
            w_sel_onehot      = '0;
            w_sel_onehot[idx] = 1'b1;
            w_sel_slot        = bus.i_req_slot[idx];
            w_ptr_next        = (idx == N_REQ - 1) ? '0 : PtrW'(idx + 1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_ptr         <= '0;
         r_ack_sync    <= '0;
         r_grant       <= '0;
         r_busy        <= 1'b0;
         r_host_req    <= 1'b0;
         r_host_slot   <= 1'b0;
         r_trigger     <= 1'b0;
         r_addr        <= GOLDEN_ADDR;
         r_timeout_err <= 1'b0;
      end else begin
         r_ack_sync <= {r_ack_sync[0], bus.i_host_ack};
         r_trigger  <= 1'b0;
         // A fallback entry below overrides a simultaneous clear.
         if (bus.i_err_clr) r_timeout_err <= 1'b0;
         case (r_state)
            StIdle: begin
               if (bus.i_arm && w_sel_valid) begin
                  r_grant     <= w_sel_onehot;
                  r_host_slot <= w_sel_slot;
                  r_addr      <= w_sel_slot ? USER_ADDR : GOLDEN_ADDR;
                  r_ptr       <= w_ptr_next;
                  r_busy      <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= StHoldoff;
               end
            end
            StHoldoff: begin
               if (w_abort) begin
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end else if (r_cnt == CntW'(HOLDOFF_CYCLES)) begin
                  r_host_req <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= StHostReq;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StHostReq: begin
               if (w_abort) begin
                  r_host_req <= 1'b0;
                  r_grant    <= '0;
                  r_busy     <= 1'b0;
                  r_state    <= StIdle;
               end else if (r_ack_sync[1]) begin
                  r_host_req <= 1'b0;
                  r_state    <= StWaitRel;
               end else if (r_cnt == CntW'(ACK_TIMEOUT_CYCLES - 1)) begin
                  r_host_req    <= 1'b0;
                  r_trigger     <= 1'b1;
                  r_timeout_err <= 1'b1;
                  r_state       <= StFallback;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StWaitRel: begin
               if (!r_ack_sync[1]) begin
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end
            end
            StFallback: begin
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               r_host_req <= 1'b0;
               r_grant    <= '0;
               r_busy     <= 1'b0;
               r_state    <= StIdle;
            end
         endcase
      end
   end

   assign bus.o_grant          = r_grant;
   assign bus.o_busy           = r_busy;
   assign bus.o_host_req       = r_host_req;
   assign bus.o_host_slot      = r_host_slot;
   assign bus.o_reboot_trigger = r_trigger;
   assign bus.o_reboot_addr    = r_addr;
   assign bus.o_timeout_err    = r_timeout_err;
endmodule

// File: tb/tb_ota_reboot_sequencer.sv
// Directed bench for ota_reboot_sequencer (HOLDOFF_CYCLES=8, ACK_TIMEOUT_CYCLES=32).
// Abort scenario runs only when OTA_REBOOT_ABORT_EN is defined.
module tb_ota_reboot_sequencer;
   localparam int unsigned N_REQ = 3;
   localparam int unsigned HOLD  = 8;
   localparam int unsigned TMO   = 32;
   localparam logic [31:0] GOLD  = 32'h0000_0000;
   localparam logic [31:0] USER  = 32'h0010_0000;

   logic clk = 1'b0;
   logic rst;
   int   n_vec    = 0;
   int   n_err    = 0;
   int   trig_cnt = 0;

   ota_reboot_sequencer_if #(.N_REQ(N_REQ)) bus_if ();

   ota_reboot_sequencer #(
      .N_REQ             (N_REQ),
      .HOLDOFF_CYCLES    (HOLD),
      .ACK_TIMEOUT_CYCLES(TMO),
      .GOLDEN_ADDR       (GOLD),
      .USER_ADDR         (USER)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus_if.o_reboot_trigger === 1'b1) trig_cnt++;

   task automatic wait_host_req(input logic val, input int limit, output int cycles,
                                output bit ok);
      ok = 1'b0;
      cycles = 0;
      while (cycles < limit && !ok) begin
         @(negedge clk);
         cycles++;
         if (bus_if.o_host_req === val) ok = 1'b1;
      end
   endtask

   task automatic wait_busy(input logic val, input int limit, output int cycles,
                            output bit ok);
      ok = 1'b0;
      cycles = 0;
      while (cycles < limit && !ok) begin
         @(negedge clk);
         cycles++;
         if (bus_if.o_busy === val) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_if.i_arm = 1'b0;
      bus_if.i_req = '0;
      bus_if.i_req_slot = '0;
      bus_if.i_host_ack = 1'b0;
      bus_if.i_err_clr = 1'b0;
`ifdef OTA_REBOOT_ABORT_EN
      bus_if.i_abort = 1'b0;
`endif
      repeat (2) @(negedge clk);
      n_vec++;
      if (bus_if.o_grant !== 3'b000 || bus_if.o_busy !== 1'b0 || bus_if.o_host_req !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctl: grant=%b busy=%b host_req=%b, want 000/0/0",
                  bus_if.o_grant, bus_if.o_busy, bus_if.o_host_req);
      end
      n_vec++;
      if (bus_if.o_host_slot !== 1'b0 || bus_if.o_reboot_trigger !== 1'b0 ||
          bus_if.o_timeout_err !== 1'b0 || bus_if.o_reboot_addr !== GOLD) begin
         n_err++;
         $display("FAIL reset_out: slot=%b trig=%b err=%b addr=%h, want 0/0/0/%h",
                  bus_if.o_host_slot, bus_if.o_reboot_trigger, bus_if.o_timeout_err,
                  bus_if.o_reboot_addr, GOLD);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_handshake();
      int c;
      bit ok;
      bus_if.i_arm = 1'b1;
      bus_if.i_req = 3'b010;
      bus_if.i_req_slot = 3'b010;
      @(negedge clk);
      bus_if.i_req = 3'b000;
      n_vec++;
      if (bus_if.o_grant !== 3'b010 || bus_if.o_busy !== 1'b1) begin
         n_err++;
         $display("FAIL hs_grant: grant=%b busy=%b, want 010/1", bus_if.o_grant, bus_if.o_busy);
      end
      wait_host_req(1'b1, 40, c, ok);
      n_vec++;
      if (!ok || c != HOLD + 1) begin
         n_err++;
         $display("FAIL hs_host_req_latency: got %0d cycles (seen=%0d), want %0d", c, ok, HOLD + 1);
      end
      n_vec++;
      if (bus_if.o_host_slot !== 1'b1 || bus_if.o_reboot_addr !== USER) begin
         n_err++;
         $display("FAIL hs_slot_addr: slot=%b addr=%h, want 1/%h",
                  bus_if.o_host_slot, bus_if.o_reboot_addr, USER);
      end
      repeat (5) @(negedge clk);
      bus_if.i_host_ack = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if (bus_if.o_host_req !== 1'b0 || bus_if.o_busy !== 1'b1) begin
         n_err++;
         $display("FAIL hs_wait_rel: host_req=%b busy=%b, want 0/1",
                  bus_if.o_host_req, bus_if.o_busy);
      end
      bus_if.i_host_ack = 1'b0;
      wait_busy(1'b0, 10, c, ok);
      n_vec++;
      if (!ok || c < 2 || c > 3) begin
         n_err++;
         $display("FAIL hs_release: idle after %0d cycles (seen=%0d), want 2..3", c, ok);
      end
      n_vec++;
      if (bus_if.o_grant !== 3'b000 || bus_if.o_timeout_err !== 1'b0 || trig_cnt != 0) begin
         n_err++;
         $display("FAIL hs_end: grant=%b err=%b trig_pulses=%0d, want 000/0/0",
                  bus_if.o_grant, bus_if.o_timeout_err, trig_cnt);
      end
   endtask

   task automatic test_timeout();
      int c;
      int hr;
      int t0;
      bit ok;
      bus_if.i_req = 3'b001;
      bus_if.i_req_slot = 3'b000;
      @(negedge clk);
      bus_if.i_req = 3'b000;
      n_vec++;
      if (bus_if.o_grant !== 3'b001) begin
         n_err++;
         $display("FAIL to_grant: grant=%b, want 001", bus_if.o_grant);
      end
      wait_host_req(1'b1, 40, c, ok);
      t0 = trig_cnt;
      hr = ok ? 1 : 0;
      while (ok && bus_if.o_host_req === 1'b1 && hr < 100) begin
         @(negedge clk);
         if (bus_if.o_host_req === 1'b1) hr++;
      end
      n_vec++;
      if (hr != TMO) begin
         n_err++;
         $display("FAIL to_host_req_len: host_req high %0d cycles, want %0d", hr, TMO);
      end
      n_vec++;
      if (bus_if.o_reboot_trigger !== 1'b1 || bus_if.o_reboot_addr !== GOLD ||
          bus_if.o_timeout_err !== 1'b1) begin
         n_err++;
         $display("FAIL to_fallback: trig=%b addr=%h err=%b, want 1/%h/1",
                  bus_if.o_reboot_trigger, bus_if.o_reboot_addr, bus_if.o_timeout_err, GOLD);
      end
      @(negedge clk);
      n_vec++;
      if (bus_if.o_reboot_trigger !== 1'b0 || bus_if.o_busy !== 1'b0 ||
          bus_if.o_grant !== 3'b000) begin
         n_err++;
         $display("FAIL to_back_idle: trig=%b busy=%b grant=%b, want 0/0/000",
                  bus_if.o_reboot_trigger, bus_if.o_busy, bus_if.o_grant);
      end
      repeat (4) @(negedge clk);
      n_vec++;
      if (trig_cnt - t0 != 1 || bus_if.o_timeout_err !== 1'b1) begin
         n_err++;
         $display("FAIL to_single_pulse: pulses=%0d err=%b, want 1/1",
                  trig_cnt - t0, bus_if.o_timeout_err);
      end
      bus_if.i_err_clr = 1'b1;
      @(negedge clk);
      bus_if.i_err_clr = 1'b0;
      n_vec++;
      if (bus_if.o_timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL to_err_clr: err=%b, want 0", bus_if.o_timeout_err);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_rr [4];
      int c;
      bit ok;
      exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
      rst = 1'b1;
      bus_if.i_req = 3'b111;
      bus_if.i_req_slot = 3'b000;
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 4; s++) begin
         wait_busy(1'b1, 20, c, ok);
         n_vec++;
         if (!ok || bus_if.o_grant !== exp_rr[s]) begin
            n_err++;
            $display("FAIL rr_grant_%0d: grant=%b (seen=%0d), want %b",
                     s, bus_if.o_grant, ok, exp_rr[s]);
         end
         wait_host_req(1'b1, 40, c, ok);
         bus_if.i_host_ack = 1'b1;
         wait_host_req(1'b0, 10, c, ok);
         bus_if.i_host_ack = 1'b0;
         wait_busy(1'b0, 10, c, ok);
      end
      bus_if.i_req = 3'b000;
      @(negedge clk);
   endtask

   task automatic test_gating();
      int busy_seen;
      int bad_grant;
      int c;
      bit ok;
      bus_if.i_arm = 1'b0;
      bus_if.i_req = 3'b100;
      busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_if.o_busy !== 1'b0) busy_seen++;
      end
      n_vec++;
      if (busy_seen != 0) begin
         n_err++;
         $display("FAIL gate_arm: busy high %0d cycles, want 0", busy_seen);
      end
      bus_if.i_req = 3'b001;
      bus_if.i_arm = 1'b1;
      @(negedge clk);
      bus_if.i_req = 3'b000;
      n_vec++;
      if (bus_if.o_grant !== 3'b001) begin
         n_err++;
         $display("FAIL gate_grant: grant=%b, want 001", bus_if.o_grant);
      end
      @(negedge clk);
      bus_if.i_req = 3'b100;
      @(negedge clk);
      bus_if.i_req = 3'b000;
      wait_host_req(1'b1, 40, c, ok);
      bus_if.i_host_ack = 1'b1;
      wait_host_req(1'b0, 10, c, ok);
      bus_if.i_host_ack = 1'b0;
      wait_busy(1'b0, 10, c, ok);
      bad_grant = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_if.o_busy !== 1'b0 || bus_if.o_grant !== 3'b000) bad_grant++;
      end
      n_vec++;
      if (!ok || bad_grant != 0) begin
         n_err++;
         $display("FAIL gate_drop: idle_seen=%0d late_grant_cycles=%0d, want 1/0", ok, bad_grant);
      end
   endtask

   task automatic test_reset_midop();
      int c;
      bit ok;
      bus_if.i_req = 3'b010;
      bus_if.i_req_slot = 3'b010;
      @(negedge clk);
      bus_if.i_req = 3'b000;
      wait_host_req(1'b1, 40, c, ok);
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (!ok || bus_if.o_host_req !== 1'b0 || bus_if.o_grant !== 3'b000 ||
          bus_if.o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_async: host_req=%b grant=%b busy=%b (seen=%0d), want 0/000/0",
                  bus_if.o_host_req, bus_if.o_grant, bus_if.o_busy, ok);
      end
      n_vec++;
      if (bus_if.o_reboot_addr !== GOLD) begin
         n_err++;
         $display("FAIL rst_addr: addr=%h, want %h", bus_if.o_reboot_addr, GOLD);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

`ifdef OTA_REBOOT_ABORT_EN
   task automatic test_abort();
      int hr_seen;
      bus_if.i_req = 3'b001;
      bus_if.i_req_slot = 3'b000;
      @(negedge clk);
      bus_if.i_req = 3'b000;
      repeat (3) @(negedge clk);
      bus_if.i_abort = 1'b1;
      @(negedge clk);
      bus_if.i_abort = 1'b0;
      n_vec++;
      if (bus_if.o_busy !== 1'b0 || bus_if.o_grant !== 3'b000) begin
         n_err++;
         $display("FAIL abort_idle: busy=%b grant=%b, want 0/000", bus_if.o_busy, bus_if.o_grant);
      end
      hr_seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus_if.o_host_req !== 1'b0) hr_seen++;
      end
      n_vec++;
      if (hr_seen != 0 || bus_if.o_timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL abort_quiet: host_req cycles=%0d err=%b, want 0/0",
                  hr_seen, bus_if.o_timeout_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_handshake();
      test_timeout();
      test_round_robin();
      test_gating();
      test_reset_midop();
`ifdef OTA_REBOOT_ABORT_EN
      test_abort();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish within 500000 time units");
      $fatal(1);
   end
endmodule
